// File: rtl/exec_alu_arbiter_pkg.sv
// Shared definitions for the execute-ALU arbiter: operation codes and arbiter state.
package exec_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_LLS  = 5'd1;
  localparam logic [4:0] OP_SLT  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_LRS  = 5'd5;
  localparam logic [4:0] OP_SLTU = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_SUB  = 5'd8;
  localparam logic [4:0] OP_ARS  = 5'd13;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BNE  = 5'd17;
  localparam logic [4:0] OP_BLT  = 5'd20;
  localparam logic [4:0] OP_BGE  = 5'd21;
  localparam logic [4:0] OP_BLTU = 5'd22;
  localparam logic [4:0] OP_BGEU = 5'd23;
  localparam logic [4:0] OP_LUI  = 5'd24;
  localparam logic [4:0] OP_JALR = 5'd25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } arb_state_t;

  function automatic logic is_branch(input logic [4:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/exec_alu_arbiter_exec.sv
// Combinational execute ALU shared by both arbiter ports.
module exec
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      operation,
  output logic [XLEN-1:0] result,
  output logic            bcond
);

  logic signed [XLEN-1:0] s1;
  logic signed [XLEN-1:0] s2;
  logic [4:0]             shamt;

  assign s1    = op1;
  assign s2    = op2;
  assign shamt = op2[4:0];

  always_comb begin
    result = '0;
    bcond  = 1'b0;
    case (operation)
      OP_ADD:  result = op1 + op2;
      OP_SUB:  result = op1 - op2;
      OP_XOR:  result = op1 ^ op2;
      OP_OR:   result = op1 | op2;
      OP_AND:  result = op1 & op2;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, s1 < s2};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, op1 < op2};
      OP_LLS:  result = op1 << shamt;
      OP_LRS:  result = op1 >> shamt;
      OP_ARS:  result = s1 >>> shamt;
      OP_BEQ:  bcond  = (op1 == op2);
      OP_BNE:  bcond  = (op1 != op2);
      OP_BLT:  bcond  = (s1 < s2);
      OP_BGE:  bcond  = (s1 >= s2);
      OP_BLTU: bcond  = (op1 < op2);
      OP_BGEU: bcond  = (op1 >= op2);
      OP_LUI:  result = op2;
      OP_JALR: result = op1 + op2;
      default: begin
        result = '0;
        bcond  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exec_alu_arbiter.sv
// Two-port arbiter around the shared execute ALU with a one-deep result hold per owner.
// Optional EXEC_ARB_PERF_EN adds grant/stall performance counters.
module exec_alu_arbiter
  import exec_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [4:0]      req0_operation,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic [4:0]      req1_operation,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_bcond,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_bcond
`ifdef EXEC_ARB_PERF_EN
  ,
  output logic [31:0]     perf_grant0,
  output logic [31:0]     perf_grant1,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_t      state_p1;
  logic [3:0]      starve_cnt_p1;
  logic            vld0_p1, vld1_p1;
  logic [XLEN-1:0] res0_p1, res1_p1;
  logic            bc0_p1, bc1_p1;

  logic            free, gnt0, gnt1, acc0, acc1;
  logic [XLEN-1:0] alu_op1_p0, alu_op2_p0, alu_res_p0, mask_res_p0;
  logic [4:0]      alu_opc_p0;
  logic            alu_bc_p0, mask_bc_p0;

  // Keeps only the architecturally meaningful part of the raw ALU output.
  function automatic logic [XLEN:0] mask_result(input logic [4:0] op,
                                                input logic [XLEN-1:0] r,
                                                input logic bc);
    logic [XLEN-1:0] res;
    logic            b;
    res = '0;
    b   = 1'b0;
    if (!is_branch(op)) begin
      case (op)
        OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND,
        OP_SLT, OP_SLTU, OP_LLS, OP_LRS, OP_ARS: res = r;
        default:                                 res = '0;
      endcase
    end else begin
      case (op)
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: b = bc;
        OP_JALR: res = r & {{(XLEN-1){1'b1}}, 1'b0};
        OP_LUI:  res = r;
        default: begin
          res = '0;
          b   = 1'b0;
        end
      endcase
    end
    return {b, res};
  endfunction

  assign free = (state_p1 == IDLE) ||
                ((state_p1 == HOLD0) && rsp0_ready) ||
                ((state_p1 == HOLD1) && rsp1_ready);

  assign gnt1 = req1_valid && ((starve_cnt_p1 == SMAX) || !req0_valid);
  assign gnt0 = req0_valid && !gnt1;

  assign req0_ready = rst_n && free && gnt0;
  assign req1_ready = rst_n && free && gnt1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  // Stage p0: operand select, shared ALU, result masking
  assign alu_op1_p0 = gnt1 ? req1_op1       : req0_op1;
  assign alu_op2_p0 = gnt1 ? req1_op2       : req0_op2;
  assign alu_opc_p0 = gnt1 ? req1_operation : req0_operation;

  exec #(.XLEN(XLEN)) u_exec (
    .op1       (alu_op1_p0),
    .op2       (alu_op2_p0),
    .operation (alu_opc_p0),
    .result    (alu_res_p0),
    .bcond     (alu_bc_p0)
  );

  assign {mask_bc_p0, mask_res_p0} = mask_result(alu_opc_p0, alu_res_p0, alu_bc_p0);

  // Stage p1: hold FSM and per-port result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1      <= IDLE;
      vld0_p1       <= 1'b0;
      vld1_p1       <= 1'b0;
      res0_p1       <= '0;
      res1_p1       <= '0;
      bc0_p1        <= 1'b0;
      bc1_p1        <= 1'b0;
      starve_cnt_p1 <= 4'd0;
    end else begin
      if (acc0) begin
        state_p1 <= HOLD0;
        vld0_p1  <= 1'b1;
        vld1_p1  <= 1'b0;
        res0_p1  <= mask_res_p0;
        bc0_p1   <= mask_bc_p0;
      end else if (acc1) begin
        state_p1 <= HOLD1;
        vld0_p1  <= 1'b0;
        vld1_p1  <= 1'b1;
        res1_p1  <= mask_res_p0;
        bc1_p1   <= mask_bc_p0;
      end else if (free) begin
        state_p1 <= IDLE;
        vld0_p1  <= 1'b0;
        vld1_p1  <= 1'b0;
      end

      if (!req1_valid || acc1) begin
        starve_cnt_p1 <= 4'd0;
      end else if (starve_cnt_p1 != SMAX) begin
        starve_cnt_p1 <= starve_cnt_p1 + 4'd1;
      end
    end
  end

  assign rsp0_valid  = vld0_p1;
  assign rsp0_result = res0_p1;
  assign rsp0_bcond  = bc0_p1;
  assign rsp1_valid  = vld1_p1;
  assign rsp1_result = res1_p1;
  assign rsp1_bcond  = bc1_p1;

`ifdef EXEC_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (acc0) perf_grant0 <= perf_grant0 + 32'd1;
      if (acc1) perf_grant1 <= perf_grant1 + 32'd1;
      if ((req0_valid && !req0_ready) || (req1_valid && !req1_ready))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_alu_arbiter.sv
// Bench for exec_alu_arbiter: directed scenarios followed by a randomized scoreboard run.
module tb_exec_alu_arbiter;

  typedef struct packed {
    logic [31:0] r;
    logic        b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [4:0]  req0_operation, req1_operation;
  logic        rsp0_valid, rsp0_ready, rsp0_bcond;
  logic        rsp1_valid, rsp1_ready, rsp1_bcond;
  logic [31:0] rsp0_result, rsp1_result;
`ifdef EXEC_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

  int   tests = 0;
  int   fails = 0;
  bit   sb_on = 1'b0;
  int   held, cnt, g0n, g1n, stn;
  bit   acc0_pred, acc1_pred;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  exec_alu_arbiter #(.STARVE_MAX(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_operation(req0_operation),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_operation(req1_operation),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_bcond(rsp0_bcond),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_bcond(rsp1_bcond)
`ifdef EXEC_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference ALU semantics straight from the operation definitions.
  function automatic exp_t ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.r = 32'd0;
    e.b = 1'b0;
    case (op)
      5'd0:  e.r = a + b;
      5'd8:  e.r = a - b;
      5'd4:  e.r = a ^ b;
      5'd3:  e.r = a | b;
      5'd7:  e.r = a & b;
      5'd2:  e.r = {31'd0, $signed(a) < $signed(b)};
      5'd6:  e.r = {31'd0, a < b};
      5'd1:  e.r = a << b[4:0];
      5'd5:  e.r = a >> b[4:0];
      5'd13: e.r = 32'($signed(a) >>> b[4:0]);
      5'd16: e.b = (a == b);
      5'd17: e.b = (a != b);
      5'd20: e.b = ($signed(a) < $signed(b));
      5'd21: e.b = ($signed(a) >= $signed(b));
      5'd22: e.b = (a < b);
      5'd23: e.b = (a >= b);
      5'd24: e.r = b;
      5'd25: e.r = (a + b) & 32'hFFFF_FFFE;
      default: ;
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(output logic [4:0] op, output logic [31:0] a, output logic [31:0] b);
    op = 5'($urandom_range(0, 31));
    a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
    b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    if ($urandom_range(0, 5) == 0) b = a;
  endtask

  // Arbitration model: predicts readies, holds and accepts from the grant rules.
  always @(negedge clk) begin
    bit free, want1, e0, e1;
    if (sb_on) begin
      chk1("rsp0_valid_model", rsp0_valid, held == 0);
      chk1("rsp1_valid_model", rsp1_valid, held == 1);
      free  = (held < 0) || (held == 0 && rsp0_ready) || (held == 1 && rsp1_ready);
      want1 = req1_valid && ((cnt == 4) || !req0_valid);
      e0    = free && req0_valid && !want1;
      e1    = free && want1;
      chk1("req0_ready_model", req0_ready, e0);
      chk1("req1_ready_model", req1_ready, e1);
      if ((req0_valid && !e0) || (req1_valid && !e1)) stn++;
      if (e0) begin
        q0.push_back(ref_op(req0_operation, req0_op1, req0_op2));
        held = 0;
        g0n++;
      end else if (e1) begin
        q1.push_back(ref_op(req1_operation, req1_op1, req1_op2));
        held = 1;
        g1n++;
      end else if (free) begin
        held = -1;
      end
      if (!req1_valid || e1) cnt = 0;
      else if (cnt < 4) cnt++;
      acc0_pred = e0;
      acc1_pred = e1;
    end
  end

  // Response monitor: pops expected results as each port consumes them.
  always @(negedge clk) begin
    if (sb_on) begin
      if (rsp0_valid) begin
        if (q0.size() == 0) begin
          fails++;
          tests++;
          $display("FAIL rsp0_spurious: result 0x%08h with no expected entry", rsp0_result);
        end else begin
          chk32("rsp0_result_sb", rsp0_result, q0[0].r);
          chk1("rsp0_bcond_sb", rsp0_bcond, q0[0].b);
          if (rsp0_ready) void'(q0.pop_front());
        end
      end
      if (rsp1_valid) begin
        if (q1.size() == 0) begin
          fails++;
          tests++;
          $display("FAIL rsp1_spurious: result 0x%08h with no expected entry", rsp1_result);
        end else begin
          chk32("rsp1_result_sb", rsp1_result, q1[0].r);
          chk1("rsp1_bcond_sb", rsp1_bcond, q1[0].b);
          if (rsp1_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_operation = '0;
    req1_op1 = '0; req1_op2 = '0; req1_operation = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step();
    step();
    chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
    chk1("reset_rsp1_valid", rsp1_valid, 1'b0);
    chk32("reset_rsp0_result", rsp0_result, 32'd0);

    // Reset while a port-0 result is held
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_operation = 5'd0; req0_op1 = 32'd1; req0_op2 = 32'd1;
    step();
    chk1("hold_before_reset", rsp0_valid, 1'b1);
    chk32("hold_before_reset_res", rsp0_result, 32'd2);
    rsp0_ready = 1'b1;
    rst_n = 1'b0;
    #1 chk1("ready_gated_in_reset", req0_ready, 1'b0);
    step();
    chk1("reset_drops_hold", rsp0_valid, 1'b0);
    chk32("reset_clears_result", rsp0_result, 32'd0);
    rst_n = 1'b1;
    rsp0_ready = 1'b0;
    #1 chk1("ready_after_reset", req0_ready, 1'b1);

    // ADD then back-to-back SUB on port 0
    rsp0_ready = 1'b1;
    req0_operation = 5'd0; req0_op1 = 32'd5; req0_op2 = 32'd7;
    step();
    chk1("add_valid", rsp0_valid, 1'b1);
    chk32("add_result", rsp0_result, 32'd12);
    chk1("add_bcond", rsp0_bcond, 1'b0);
    chk1("b2b_ready", req0_ready, 1'b1);
    req0_operation = 5'd8;
    step();
    chk32("sub_result", rsp0_result, 32'hFFFF_FFFE);
    req0_valid = 1'b0;
    step();
    chk1("release_idle", rsp0_valid, 1'b0);

    // Starvation: both ports requesting continuously
    rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_operation = 5'd0; req0_op1 = 32'd1; req0_op2 = 32'd2;
    req1_valid = 1'b1; req1_operation = 5'd0; req1_op1 = 32'd100; req1_op2 = 32'd1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk1("starve_req1_ready", req1_ready, (i == 5) || (i == 10));
      chk1("starve_req0_ready", req0_ready, !((i == 5) || (i == 10)));
      if (i == 6) begin
        chk1("starve_rsp1_valid", rsp1_valid, 1'b1);
        chk32("starve_rsp1_result", rsp1_result, 32'd101);
        chk1("starve_rsp0_quiet", rsp0_valid, 1'b0);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Signed vs unsigned branch compare on port 1
    req1_valid = 1'b1; req1_operation = 5'd20; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'd1;
    step();
    chk1("blt_valid", rsp1_valid, 1'b1);
    chk1("blt_bcond", rsp1_bcond, 1'b1);
    chk32("blt_result", rsp1_result, 32'd0);
    chk1("blt_not_on_port0", rsp0_valid, 1'b0);
    req1_operation = 5'd22;
    step();
    chk1("bltu_bcond", rsp1_bcond, 1'b0);
    req1_valid = 1'b0;
    step();

    // JALR held under backpressure
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_operation = 5'd25; req0_op1 = 32'h1001; req0_op2 = 32'h2;
    step();
    req0_operation = 5'd0;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("jalr_hold_valid", rsp0_valid, 1'b1);
      chk32("jalr_hold_result", rsp0_result, 32'h1002);
      chk1("jalr_hold_bcond", rsp0_bcond, 1'b0);
      chk1("jalr_hold_req0_ready", req0_ready, 1'b0);
      chk1("jalr_hold_req1_ready", req1_ready, 1'b0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
    step();
    chk1("jalr_release_idle", rsp0_valid, 1'b0);

    // Randomized scoreboard phase from a clean reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    held = -1; cnt = 0; g0n = 0; g1n = 0; stn = 0;
    acc0_pred = 1'b0; acc1_pred = 1'b0;
    sb_on = 1'b1;
    for (int n = 0; n < 600; n++) begin
      step();
      if (!req0_valid || acc0_pred) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        gen(req0_operation, req0_op1, req0_op2);
      end
      if (!req1_valid || acc1_pred) begin
        req1_valid = ($urandom_range(0, 9) < 5);
        gen(req1_operation, req1_op1, req1_op2);
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (4) step();
    sb_on = 1'b0;
    chk32("drain_q0_empty", 32'(q0.size()), 32'd0);
    chk32("drain_q1_empty", 32'(q1.size()), 32'd0);
`ifdef EXEC_ARB_PERF_EN
    chk32("perf_grant0", perf_grant0, 32'(g0n));
    chk32("perf_grant1", perf_grant1, 32'(g1n));
    chk32("perf_stall", perf_stall, 32'(stn));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
